// File: rtl/fetch_unit.sv
// Program-counter / instruction-register stage for the control FSM.
// Holds PC and IR, drives the memory address, tracks halt state and counts fetches.
module fetch_unit #(
    parameter int                 AWIDTH   = 5,
    parameter int                 DWIDTH   = 8,
    parameter logic [AWIDTH-1:0]  RESET_PC = '0,
    parameter int                 CNTW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              load_ir,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              halt,
    input  logic              sel,
    input  logic              resume,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [2:0]        opcode,
    output logic [AWIDTH-1:0] ir_addr,
    output logic [AWIDTH-1:0] pc,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              halted,
    output logic [CNTW-1:0]   instr_count
);

    logic [DWIDTH-1:0] ir;
    logic              capture;
    logic              capture_prev;

    assign capture  = load_ir && mem_rd;
    assign opcode   = ir[DWIDTH-1 -: 3];
    assign ir_addr  = ir[AWIDTH-1:0];
    assign mem_addr = sel ? pc : ir_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            ir           <= '0;
            halted       <= 1'b0;
            instr_count  <= '0;
            capture_prev <= 1'b0;
        end else if (halted) begin
            // Only resume is honoured while stopped; all other state is frozen.
            if (resume)
                halted <= 1'b0;
        end else begin
            if (halt)
                halted <= 1'b1;
            if (capture)
                ir <= mem_rdata;
            // ir_addr here is the IR before any same-cycle capture.
            if (load_pc)
                pc <= ir_addr;
            else if (inc_pc)
                pc <= pc + AWIDTH'(1);
            capture_prev <= capture;
            // The FSM holds load_ir for two cycles, so count only the rising edge.
            if (capture && !capture_prev && (instr_count != {CNTW{1'b1}}))
                instr_count <= instr_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural model compared every cycle,
// plus directed literal checks. A narrow-counter instance exercises saturation.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst, mem_rd, load_ir, inc_pc, load_pc, halt, sel, resume;
    logic [7:0] mem_rdata;

    logic [2:0]  opcode,   s_opcode;
    logic [4:0]  ir_addr,  s_ir_addr;
    logic [4:0]  pc,       s_pc;
    logic [4:0]  mem_addr, s_mem_addr;
    logic        halted,   s_halted;
    logic [15:0] instr_count;
    logic [2:0]  s_instr_count;

    int checks = 0;
    int errors = 0;

    // model state
    int m_pc, m_ir, m_fetches;
    bit m_halted, m_prev;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .load_ir(load_ir), .inc_pc(inc_pc),
        .load_pc(load_pc), .halt(halt), .sel(sel), .resume(resume), .mem_rdata(mem_rdata),
        .opcode(opcode), .ir_addr(ir_addr), .pc(pc), .mem_addr(mem_addr),
        .halted(halted), .instr_count(instr_count)
    );

    fetch_unit #(.CNTW(3)) dut_s (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .load_ir(load_ir), .inc_pc(inc_pc),
        .load_pc(load_pc), .halt(halt), .sel(sel), .resume(resume), .mem_rdata(mem_rdata),
        .opcode(s_opcode), .ir_addr(s_ir_addr), .pc(s_pc), .mem_addr(s_mem_addr),
        .halted(s_halted), .instr_count(s_instr_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one instruction per rising edge of a real capture; PC jump uses old IR.
    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_ir = 0; m_halted = 0; m_fetches = 0; m_prev = 0;
        end else if (m_halted) begin
            if (resume) m_halted = 0;
        end else begin
            if (load_pc)     m_pc = m_ir % 32;
            else if (inc_pc) m_pc = (m_pc + 1) % 32;
            if (load_ir && mem_rd) begin
                if (!m_prev) m_fetches++;
                m_ir = int'(mem_rdata);
            end
            m_prev = load_ir && mem_rd;
            if (halt) m_halted = 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("pc",       int'(pc),       m_pc);
            chk("opcode",   int'(opcode),   m_ir / 32);
            chk("ir_addr",  int'(ir_addr),  m_ir % 32);
            chk("halted",   int'(halted),   int'(m_halted));
            chk("mem_addr", int'(mem_addr), sel ? m_pc : m_ir % 32);
            chk("count",    int'(instr_count), (m_fetches > 65535) ? 65535 : m_fetches);
            chk("s_pc",     int'(s_pc),     m_pc);
            chk("s_opcode", int'(s_opcode), m_ir / 32);
            chk("s_ir_addr",int'(s_ir_addr),m_ir % 32);
            chk("s_halted", int'(s_halted), int'(m_halted));
            chk("s_mem_addr", int'(s_mem_addr), sel ? m_pc : m_ir % 32);
            chk("s_count",  int'(s_instr_count), (m_fetches > 7) ? 7 : m_fetches);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        mem_rd = 0; load_ir = 0; inc_pc = 0; load_pc = 0; halt = 0; resume = 0;
    endtask

    task automatic fetch(input logic [7:0] data);
        mem_rdata = data; load_ir = 1; mem_rd = 1;
        step(); step();
        idle();
    endtask

    initial begin
        idle();
        sel = 1; mem_rdata = 8'hA7;
        // reset overrides every strobe
        rst = 1; load_pc = 1; inc_pc = 1; load_ir = 1; mem_rd = 1;
        step();
        chk("lit_rst_pc", int'(pc), 0);
        chk("lit_rst_opcode", int'(opcode), 0);
        chk("lit_rst_ir_addr", int'(ir_addr), 0);
        chk("lit_rst_halted", int'(halted), 0);
        chk("lit_rst_count", int'(instr_count), 0);
        rst = 0; idle();
        step();

        fetch(8'hA7);
        sel = 0;
        step();
        chk("lit_fetch_opcode", int'(opcode), 3'b101);
        chk("lit_fetch_ir_addr", int'(ir_addr), 5'h07);
        chk("lit_fetch_count", int'(instr_count), 1);
        chk("lit_fetch_mem_addr", int'(mem_addr), 5'h07);

        // load_ir without mem_rd must not capture
        mem_rdata = 8'h55; load_ir = 1;
        step(); idle();
        chk("lit_no_capture", int'(ir_addr), 5'h07);

        fetch(8'h1F);
        load_pc = 1; step(); idle();
        chk("lit_pc31", int'(pc), 31);
        inc_pc = 1; step(); idle();
        sel = 1; #1;
        chk("lit_wrap_pc", int'(pc), 0);
        chk("lit_wrap_mem_addr", int'(mem_addr), 0);

        fetch(8'hE9);
        load_pc = 1; inc_pc = 1; step(); idle();
        chk("lit_jump_pc", int'(pc), 5'h09);

        fetch(8'h03);
        load_pc = 1; step(); idle();
        chk("lit_pc3", int'(pc), 3);
        halt = 1; inc_pc = 1; step(); idle();
        chk("lit_halted", int'(halted), 1);
        chk("lit_halt_pc", int'(pc), 4);
        inc_pc = 1; step(); idle();
        mem_rdata = 8'hFF; load_ir = 1; mem_rd = 1; step(); idle();
        load_pc = 1; step(); idle();
        halt = 1; step(); idle();
        chk("lit_frozen_pc", int'(pc), 4);
        chk("lit_frozen_ir", int'(ir_addr), 5'h03);
        chk("lit_frozen_count", int'(instr_count), 4);
        chk("lit_still_halted", int'(halted), 1);
        resume = 1; inc_pc = 1; step(); idle();
        chk("lit_resumed", int'(halted), 0);
        chk("lit_resume_pc", int'(pc), 4);
        inc_pc = 1; step(); idle();
        chk("lit_after_resume_pc", int'(pc), 5);
        resume = 1; step(); idle();
        chk("lit_resume_noop", int'(halted), 0);

        for (int i = 0; i < 10; i++) begin
            fetch(8'(i));
            step();
        end
        chk("lit_count14", int'(instr_count), 14);
        chk("lit_sat", int'(s_instr_count), 7);

        rst = 1; step(); rst = 0;
        chk("lit_rst2_count", int'(instr_count), 0);
        chk("lit_rst2_s_count", int'(s_instr_count), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
